// File: rtl/hit_merge_arb.sv
// Merges hits from two rasterizer pipes into one z-buffer stream. Each pipe has
// its own FIFO; a round-robin arbiter feeds a single registered output stage.
module hit_merge_arb #(
    parameter int SIGFIG = 24,
    parameter int AXIS   = 3,
    parameter int COLORS = 3,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] hit_R18S     [AXIS],
    input  logic        [SIGFIG-1:0] color_R18U   [COLORS],
    input  logic                     hit_valid_R18H,
    input  logic signed [SIGFIG-1:0] hit_R18S_2   [AXIS],
    input  logic        [SIGFIG-1:0] color_R18U_2 [COLORS],
    input  logic                     hit_valid_R18H_2,
    input  logic                     zb_ready_H,
    output logic signed [SIGFIG-1:0] hit_R19S     [AXIS],
    output logic        [SIGFIG-1:0] color_R19U   [COLORS],
    output logic                     hit_valid_R19H,
    output logic                     src_R19H,
    output logic                     halt_RnnnnL,
    output logic                     ovf_H
);
    localparam int EW = SIGFIG * (AXIS + COLORS);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [CW-1:0] HALT_LVL = CW'(DEPTH - 2);

    logic [EW-1:0] in_word [2];
    logic [1:0]    in_valid;
    logic [EW-1:0] mem_q [2][DEPTH];
    logic [PW-1:0] wr_ptr_q [2];
    logic [PW-1:0] wr_ptr_d [2];
    logic [PW-1:0] rd_ptr_q [2];
    logic [PW-1:0] rd_ptr_d [2];
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [1:0]    push;
    logic [1:0]    pop;
    logic [1:0]    nonempty;
    logic          free;
    logic          grant_any;
    logic          gsel;
    logic          rr_q, rr_d;
    logic [EW-1:0] out_q, out_d;
    logic          valid_q, valid_d;
    logic          src_q, src_d;
    logic          halt_q, halt_d;
    logic          ovf_q, ovf_d;

    assign in_valid = {hit_valid_R18H_2, hit_valid_R18H};

    // Each FIFO entry is {colors, axes} packed with axis 0 in the low bits.
    always_comb begin
        in_word[0] = '0;
        in_word[1] = '0;
        for (int a = 0; a < AXIS; a++) begin
            in_word[0][a*SIGFIG +: SIGFIG] = hit_R18S[a];
            in_word[1][a*SIGFIG +: SIGFIG] = hit_R18S_2[a];
        end
        for (int c = 0; c < COLORS; c++) begin
            in_word[0][(AXIS+c)*SIGFIG +: SIGFIG] = color_R18U[c];
            in_word[1][(AXIS+c)*SIGFIG +: SIGFIG] = color_R18U_2[c];
        end
    end

    always_comb begin
        nonempty  = {(cnt_q[1] != '0), (cnt_q[0] != '0)};
        free      = !valid_q || zb_ready_H;
        grant_any = free && (nonempty != 2'b00);
        gsel      = (nonempty == 2'b11) ? rr_q : nonempty[1];
        rr_d      = rr_q;
        out_d     = out_q;
        src_d     = src_q;
        valid_d   = valid_q;
        ovf_d     = ovf_q;
        pop       = '0;
        push      = '0;
        if (free) begin
            valid_d = grant_any;
            if (grant_any) begin
                pop[gsel] = 1'b1;
                out_d     = mem_q[gsel][rd_ptr_q[gsel]];
                src_d     = gsel;
                rr_d      = !gsel;
            end
        end
        // Acceptance looks only at the pre-edge count; a full FIFO drops even if it pops now.
        for (int k = 0; k < 2; k++) begin
            push[k] = in_valid[k] && (cnt_q[k] < FULL);
            if (in_valid[k] && (cnt_q[k] == FULL)) begin
                ovf_d = 1'b1;
            end
            cnt_d[k]    = cnt_q[k] + CW'(push[k]) - CW'(pop[k]);
            wr_ptr_d[k] = wr_ptr_q[k] + PW'(push[k]);
            rd_ptr_d[k] = rd_ptr_q[k] + PW'(pop[k]);
        end
        halt_d = !((cnt_d[0] >= HALT_LVL) || (cnt_d[1] >= HALT_LVL));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                cnt_q[k]    <= '0;
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
            end
            rr_q    <= 1'b0;
            out_q   <= '0;
            valid_q <= 1'b0;
            src_q   <= 1'b0;
            halt_q  <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                cnt_q[k]    <= cnt_d[k];
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
            end
            rr_q    <= rr_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            src_q   <= src_d;
            halt_q  <= halt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (push[k] && !rst) begin
                mem_q[k][wr_ptr_q[k]] <= in_word[k];
            end
        end
    end

    always_comb begin
        for (int a = 0; a < AXIS; a++) begin
            hit_R19S[a] = out_q[a*SIGFIG +: SIGFIG];
        end
        for (int c = 0; c < COLORS; c++) begin
            color_R19U[c] = out_q[(AXIS+c)*SIGFIG +: SIGFIG];
        end
    end

    assign hit_valid_R19H = valid_q;
    assign src_R19H       = src_q;
    assign halt_RnnnnL    = halt_q;
    assign ovf_H          = ovf_q;

endmodule
